// File: rtl/bocks_pkg.sv
// Shared types for the ioctl-to-SDRAM download loader: FSM states, FIFO entry
// layout and bus widths.
package bocks_pkg;
    localparam int IOCTL_AW = 27;
    localparam int WADDR_W  = 25;
    localparam int WDATA_W  = 16;
    localparam int BE_W     = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [WADDR_W-1:0] addr;
        logic [WDATA_W-1:0] data;
        logic [BE_W-1:0]    be;
    } fifo_entry_t;
endpackage

// File: rtl/ioctl_sdram_loader_if.sv
// hps_io download side and SDRAM write side of the loader, bundled together.
interface ioctl_sdram_loader_if;
    import bocks_pkg::*;

    logic                ioctl_download;
    logic                ioctl_wr;
    logic [IOCTL_AW-1:0] ioctl_addr;
    logic [7:0]          ioctl_dout;
    logic                ioctl_wait;

    logic                wr_req;
    logic [WADDR_W-1:0]  wr_addr;
    logic [WDATA_W-1:0]  wr_data;
    logic [BE_W-1:0]     wr_be;
    logic                wr_ack;

    // loader side
    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, wr_ack,
        output ioctl_wait, wr_req, wr_addr, wr_data, wr_be
    );

    // host / SDRAM controller side
    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, wr_ack,
        input  ioctl_wait, wr_req, wr_addr, wr_data, wr_be
    );
endinterface

// File: rtl/loader_fifo.sv
// Registered write FIFO; pushes while full are dropped, afull is a registered
// flag that tracks count >= DEPTH-2 cycle-exactly.
module loader_fifo
    import bocks_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        push,
    input  fifo_entry_t push_ent,
    input  logic        pop,
    output fifo_entry_t head,
    output logic        empty,
    output logic        full,
    output logic        afull
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_LVL  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_LVL = CW'(DEPTH - 2);

    fifo_entry_t   mem_q [DEPTH];
    fifo_entry_t   mem_d [DEPTH];
    logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          afull_q, afull_d;
    logic          do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == FULL_LVL);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem_q[rp_q];
    assign afull   = afull_q;

    always_comb begin
        mem_d = mem_q;
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (do_push) begin
            mem_d[wp_q] = push_ent;
            wp_d        = wp_q + 1'b1;
        end
        if (do_pop) rp_d = rp_q + 1'b1;
        if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
        else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
        afull_d = (cnt_d >= AFULL_LVL);
    end

    // Storage needs no reset: nothing is visible until count says so.
    always_ff @(posedge clk_sys) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            afull_q <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            cnt_q   <= cnt_d;
            afull_q <= afull_d;
        end
    end
endmodule

// File: rtl/ioctl_sdram_loader.sv
// Packs hps_io download bytes into 16-bit SDRAM word writes through a small
// FIFO, with backpressure, completion and sticky overflow reporting.
module ioctl_sdram_loader
    import bocks_pkg::*;
#(
    parameter int                 FIFO_DEPTH = 8,
    parameter logic [WADDR_W-1:0] WORD_BASE  = 25'h0
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    ioctl_sdram_loader_if.slave  bus,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow
);
    state_e             state_q, state_d;
    logic               dl_q, dl_d;
    logic               pk_vld_q, pk_vld_d;
    logic [WADDR_W-1:0] pk_addr_q, pk_addr_d;
    logic [WDATA_W-1:0] pk_data_q, pk_data_d;
    logic [BE_W-1:0]    pk_be_q, pk_be_d;
    logic               ovf_q, ovf_d;

    logic               rise, fall, accept, push;
    fifo_entry_t        push_ent, head;
    logic               fifo_empty, fifo_full, fifo_afull;
    logic [WADDR_W-1:0] byte_waddr;
    logic [BE_W-1:0]    lane_be, merged_be;
    logic [WDATA_W-1:0] lane_data, merged_data;
    logic               unused_addr_msb;

    assign unused_addr_msb = bus.ioctl_addr[IOCTL_AW-1];

    always_comb begin
        dl_d        = bus.ioctl_download;
        rise        = bus.ioctl_download & ~dl_q;
        fall        = ~bus.ioctl_download & dl_q;
        // A byte arriving on the very cycle download rises belongs to the new load.
        accept      = bus.ioctl_wr & bus.ioctl_download & ((state_q == ST_LOAD) | rise);
        byte_waddr  = bus.ioctl_addr[WADDR_W:1];
        lane_be     = bus.ioctl_addr[0] ? 2'b10 : 2'b01;
        lane_data   = bus.ioctl_addr[0] ? {bus.ioctl_dout, 8'h00} : {8'h00, bus.ioctl_dout};
        merged_be   = pk_be_q | lane_be;
        merged_data = bus.ioctl_addr[0] ? {bus.ioctl_dout, pk_data_q[7:0]}
                                        : {pk_data_q[15:8], bus.ioctl_dout};
    end

    always_comb begin
        state_d   = state_q;
        pk_vld_d  = pk_vld_q;
        pk_addr_d = pk_addr_q;
        pk_data_d = pk_data_q;
        pk_be_d   = pk_be_q;
        push      = 1'b0;
        push_ent  = '{addr: pk_addr_q + WORD_BASE, data: pk_data_q, be: pk_be_q};

        unique case (state_q)
            ST_IDLE, ST_DONE: if (rise) state_d = ST_LOAD;
            ST_LOAD:          if (fall) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (rise)                          state_d = ST_LOAD;
                else if (!pk_vld_q && fifo_empty)  state_d = ST_DONE;
            end
            default:          state_d = ST_IDLE;
        endcase

        if (accept) begin
            if (pk_vld_q && byte_waddr != pk_addr_q) begin
                // Flush the stale partial word, new byte starts a fresh one.
                push      = 1'b1;
                pk_vld_d  = 1'b1;
                pk_addr_d = byte_waddr;
                pk_data_d = lane_data;
                pk_be_d   = lane_be;
            end else begin
                pk_addr_d = byte_waddr;
                pk_data_d = pk_vld_q ? merged_data : lane_data;
                pk_be_d   = pk_vld_q ? merged_be : lane_be;
                pk_vld_d  = 1'b1;
                if (pk_be_d == 2'b11) begin
                    push      = 1'b1;
                    push_ent  = '{addr: byte_waddr + WORD_BASE, data: pk_data_d, be: 2'b11};
                    pk_vld_d  = 1'b0;
                    pk_addr_d = '0;
                    pk_data_d = '0;
                    pk_be_d   = '0;
                end
            end
        end else if (state_q == ST_LOAD && fall && pk_vld_q) begin
            push      = 1'b1;
            pk_vld_d  = 1'b0;
            pk_addr_d = '0;
            pk_data_d = '0;
            pk_be_d   = '0;
        end
    end

    always_comb begin
        ovf_d = ovf_q | (push & fifo_full);
        if (rise && state_q != ST_LOAD) ovf_d = 1'b0;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            // Treat download as already high so a level held across reset is not a new start.
            dl_q      <= 1'b1;
            pk_vld_q  <= 1'b0;
            pk_addr_q <= '0;
            pk_data_q <= '0;
            pk_be_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dl_q      <= dl_d;
            pk_vld_q  <= pk_vld_d;
            pk_addr_q <= pk_addr_d;
            pk_data_q <= pk_data_d;
            pk_be_q   <= pk_be_d;
            ovf_q     <= ovf_d;
        end
    end

    loader_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .push     (push),
        .push_ent (push_ent),
        .pop      (bus.wr_ack),
        .head     (head),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .afull    (fifo_afull)
    );

    assign bus.wr_req     = ~fifo_empty;
    assign bus.wr_addr    = fifo_empty ? '0 : head.addr;
    assign bus.wr_data    = fifo_empty ? '0 : head.data;
    assign bus.wr_be      = fifo_empty ? '0 : head.be;
    assign bus.ioctl_wait = fifo_afull;

    assign busy     = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
    assign done     = (state_q == ST_DONE);
    assign overflow = ovf_q;
endmodule

// File: tb/tb_ioctl_sdram_loader.sv
// Scoreboard bench: byte streams go through a word-packing reference model and
// every accepted SDRAM write is compared against it in order.
module tb_ioctl_sdram_loader;
    import bocks_pkg::*;

    localparam int          DEPTH = 8;
    localparam logic [24:0] WB    = 25'h1FF_FFFE;

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    logic busy, done, overflow;

    ioctl_sdram_loader_if bus ();

    ioctl_sdram_loader #(.FIFO_DEPTH(DEPTH), .WORD_BASE(WB)) dut (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .overflow (overflow)
    );

    always #5 clk_sys = ~clk_sys;

    int          n_cmp, n_err;
    int          ack_mode;
    fifo_entry_t exp_q[$];

    // ---- reference model: byte stream -> expected word writes ----
    logic        m_vld;
    logic [24:0] m_w;
    logic [15:0] m_d;
    logic [1:0]  m_be;

    function automatic void exp_add(input logic [24:0] a, input logic [15:0] d, input logic [1:0] be);
        fifo_entry_t e;
        e.addr = a;
        e.data = d;
        e.be   = be;
        exp_q.push_back(e);
    endfunction

    function automatic void m_clear();
        m_vld = 1'b0; m_w = '0; m_d = '0; m_be = '0;
    endfunction

    function automatic void m_emit();
        exp_add(m_w + WB, m_d, m_be);
        m_clear();
    endfunction

    function automatic void m_byte(input logic [26:0] a, input logic [7:0] d);
        if (m_vld && a[25:1] != m_w) m_emit();
        if (!m_vld) begin
            m_vld = 1'b1; m_w = a[25:1]; m_d = '0; m_be = '0;
        end
        if (a[0]) begin m_d[15:8] = d; m_be[1] = 1'b1; end
        else      begin m_d[7:0]  = d; m_be[0] = 1'b1; end
        if (m_be == 2'b11) m_emit();
    endfunction

    function automatic void m_flush();
        if (m_vld) m_emit();
    endfunction

    // ---- SDRAM side: ack generator and write scoreboard ----
    always @(posedge clk_sys) begin
        #2;
        case (ack_mode)
            0:       bus.wr_ack = 1'b0;
            1:       bus.wr_ack = 1'b1;
            default: bus.wr_ack = ($urandom_range(0, 2) != 0);
        endcase
    end

    fifo_entry_t got_e, hold_e, exp_e;
    logic        hold_vld = 1'b0;

    always @(negedge clk_sys) begin
        if (!reset_n) begin
            hold_vld = 1'b0;
        end else begin
            got_e = '{addr: bus.wr_addr, data: bus.wr_data, be: bus.wr_be};
            if (hold_vld) begin
                n_cmp++;
                if ({bus.wr_req, got_e} !== {1'b1, hold_e}) begin
                    n_err++;
                    $display("FAIL held_request req=%b entry=%h required req=1 entry=%h", bus.wr_req, got_e, hold_e);
                end
            end
            if (bus.wr_req === 1'b1 && bus.wr_ack === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_write got addr=%h data=%h be=%b required none", got_e.addr, got_e.data, got_e.be);
                end else begin
                    exp_e = exp_q.pop_front();
                    if (got_e !== exp_e) begin
                        n_err++;
                        $display("FAIL write_order got addr=%h data=%h be=%b required addr=%h data=%h be=%b",
                                 got_e.addr, got_e.data, got_e.be, exp_e.addr, exp_e.data, exp_e.be);
                    end
                end
            end
            hold_vld = (bus.wr_req === 1'b1) && (bus.wr_ack !== 1'b1);
            hold_e   = got_e;
        end
    end

    // ---- stimulus helpers ----
    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic dl(input bit v);
        bus.ioctl_download = v;
        tick();
    endtask

    task automatic put_byte(input logic [26:0] a, input logic [7:0] d, input bit honor);
        int t = 0;
        if (honor) begin
            while (bus.ioctl_wait === 1'b1 && t < 500) begin tick(); t++; end
            if (t >= 500) begin
                n_cmp++; n_err++;
                $display("FAIL wait_timeout ioctl_wait=%b required=0", bus.ioctl_wait);
            end
        end
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = a;
        bus.ioctl_dout = d;
        tick();
        bus.ioctl_wr   = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (done !== 1'b1 && t < 400) begin tick(); t++; end
    endtask

    // ---- scenarios ----
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if ({bus.wr_req, bus.wr_addr, bus.wr_data, bus.wr_be, bus.ioctl_wait, busy, done, overflow} !== '0) begin
            n_err++;
            $display("FAIL reset_during got=%h required=0",
                     {bus.wr_req, bus.wr_addr, bus.wr_data, bus.wr_be, bus.ioctl_wait, busy, done, overflow});
        end
        reset_n = 1'b1;
        repeat (2) tick();
        n_cmp++;
        if ({bus.wr_req, bus.wr_addr, bus.wr_data, bus.wr_be, bus.ioctl_wait, busy, done, overflow} !== '0) begin
            n_err++;
            $display("FAIL reset_after got=%h required=0",
                     {bus.wr_req, bus.wr_addr, bus.wr_data, bus.wr_be, bus.ioctl_wait, busy, done, overflow});
        end
    endtask

    task automatic test_basic();
        ack_mode = 1;
        dl(1);
        exp_add(WB + 25'd0, 16'h2211, 2'b11);
        exp_add(WB + 25'd1, 16'h4433, 2'b11);
        put_byte(27'd0, 8'h11, 0);
        n_cmp++;
        if (bus.wr_req !== 1'b0) begin n_err++; $display("FAIL basic_half_word wr_req=%b required=0", bus.wr_req); end
        put_byte(27'd1, 8'h22, 0);
        n_cmp++;
        if (bus.wr_req !== 1'b1) begin n_err++; $display("FAIL basic_latency wr_req=%b required=1", bus.wr_req); end
        put_byte(27'd2, 8'h33, 0);
        put_byte(27'd3, 8'h44, 0);
        dl(0);
        wait_done();
        n_cmp++;
        if ({done, busy} !== 2'b10) begin n_err++; $display("FAIL basic_done done,busy=%b required=10", {done, busy}); end
        n_cmp++;
        if (exp_q.size() !== 0) begin n_err++; $display("FAIL basic_missing left=%0d required=0", exp_q.size()); end
    endtask

    task automatic test_partial();
        ack_mode = 1;
        dl(1);
        n_cmp++;
        if ({done, overflow, busy} !== 3'b001) begin
            n_err++; $display("FAIL load_entry done,ovf,busy=%b required=001", {done, overflow, busy});
        end
        exp_add(WB + 25'd0, 16'hBBAA, 2'b11);
        exp_add(WB + 25'd1, 16'h00CC, 2'b01);
        put_byte(27'd0, 8'hAA, 0);
        put_byte(27'd1, 8'hBB, 0);
        put_byte(27'd2, 8'hCC, 0);
        dl(0);
        wait_done();
        n_cmp++;
        if (done !== 1'b1) begin n_err++; $display("FAIL partial_done done=%b required=1", done); end
        n_cmp++;
        if (exp_q.size() !== 0) begin n_err++; $display("FAIL partial_missing left=%0d required=0", exp_q.size()); end
    endtask

    task automatic test_no_merge();
        ack_mode = 0;
        dl(1);
        exp_add(WB + 25'd2, 16'h005A, 2'b01);
        exp_add(WB + 25'd4, 16'hA500, 2'b10);
        put_byte(27'd4, 8'h5A, 0);
        put_byte(27'd9, 8'hA5, 0);
        n_cmp++;
        if ({bus.wr_req, bus.wr_be} !== 3'b101) begin
            n_err++; $display("FAIL nomerge_first req,be=%b required=101", {bus.wr_req, bus.wr_be});
        end
        dl(0);
        ack_mode = 1;
        wait_done();
        n_cmp++;
        if (exp_q.size() !== 0 || done !== 1'b1) begin
            n_err++; $display("FAIL nomerge_drain left=%0d done=%b required 0/1", exp_q.size(), done);
        end
    endtask

    task automatic test_backpressure();
        int pushed = 0;
        logic [7:0] d;
        ack_mode = 0;
        m_clear();
        dl(1);
        for (int i = 0; i < 12; i++) begin
            n_cmp++;
            if (bus.ioctl_wait !== (pushed >= DEPTH - 2)) begin
                n_err++; $display("FAIL wait_level i=%0d wait=%b required=%b", i, bus.ioctl_wait, pushed >= DEPTH - 2);
            end
            d = 8'($urandom);
            put_byte(27'h40 + 27'(i), d, 1);
            m_byte(27'h40 + 27'(i), d);
            if (i % 2 == 1) pushed++;
        end
        n_cmp++;
        if ({bus.ioctl_wait, overflow} !== 2'b10) begin
            n_err++; $display("FAIL wait_at_six wait,ovf=%b required=10", {bus.ioctl_wait, overflow});
        end
        ack_mode = 1;
        for (int i = 12; i < 16; i++) begin
            d = 8'($urandom);
            put_byte(27'h40 + 27'(i), d, 1);
            m_byte(27'h40 + 27'(i), d);
        end
        dl(0);
        m_flush();
        wait_done();
        n_cmp++;
        if ({done, overflow} !== 2'b10) begin n_err++; $display("FAIL bp_end done,ovf=%b required=10", {done, overflow}); end
        n_cmp++;
        if (exp_q.size() !== 0) begin n_err++; $display("FAIL bp_missing left=%0d required=0", exp_q.size()); end
    endtask

    task automatic test_overflow();
        logic [7:0] d;
        logic       e_ovf;
        ack_mode = 0;
        m_clear();
        dl(1);
        for (int i = 0; i < 18; i++) begin
            d = 8'($urandom);
            put_byte(27'h100 + 27'(i), d, 0);
            if (i < 16) m_byte(27'h100 + 27'(i), d);
            e_ovf = ((i + 1) / 2 > DEPTH);
            n_cmp++;
            if (overflow !== e_ovf) begin n_err++; $display("FAIL overflow_edge i=%0d ovf=%b required=%b", i, overflow, e_ovf); end
        end
        dl(0);
        repeat (3) tick();
        n_cmp++;
        if ({overflow, done, busy} !== 3'b101) begin
            n_err++; $display("FAIL ovf_sticky_drain ovf,done,busy=%b required=101", {overflow, done, busy});
        end
        ack_mode = 1;
        wait_done();
        n_cmp++;
        if ({overflow, done} !== 2'b11) begin n_err++; $display("FAIL ovf_sticky_done ovf,done=%b required=11", {overflow, done}); end
        n_cmp++;
        if (exp_q.size() !== 0) begin n_err++; $display("FAIL ovf_missing left=%0d required=0", exp_q.size()); end
        dl(1);
        n_cmp++;
        if ({overflow, done} !== 2'b00) begin n_err++; $display("FAIL ovf_clear ovf,done=%b required=00", {overflow, done}); end
        dl(0);
        wait_done();
    endtask

    task automatic test_drain_restart();
        logic [7:0] d;
        ack_mode = 0;
        m_clear();
        dl(1);
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom);
            put_byte(27'h200 + 27'(i), d, 0);
            m_byte(27'h200 + 27'(i), d);
        end
        dl(0);
        n_cmp++;
        if ({busy, done, bus.wr_req} !== 3'b101) begin
            n_err++; $display("FAIL drain_state busy,done,req=%b required=101", {busy, done, bus.wr_req});
        end
        dl(1);
        n_cmp++;
        if ({busy, done, bus.wr_req} !== 3'b101) begin
            n_err++; $display("FAIL restart_keeps busy,done,req=%b required=101", {busy, done, bus.wr_req});
        end
        for (int i = 0; i < 2; i++) begin
            d = 8'($urandom);
            put_byte(27'h300 + 27'(i), d, 0);
            m_byte(27'h300 + 27'(i), d);
        end
        ack_mode = 1;
        dl(0);
        m_flush();
        wait_done();
        n_cmp++;
        if (exp_q.size() !== 0 || done !== 1'b1) begin
            n_err++; $display("FAIL restart_drain left=%0d done=%b required 0/1", exp_q.size(), done);
        end
    endtask

    task automatic test_reset_mid();
        ack_mode = 0;
        m_clear();
        dl(1);
        for (int i = 0; i < 6; i++) put_byte(27'h80 + 27'(i), 8'($urandom), 0);
        n_cmp++;
        if (bus.wr_req !== 1'b1) begin n_err++; $display("FAIL rmid_pending wr_req=%b required=1", bus.wr_req); end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.wr_req, busy, bus.ioctl_wait} !== 3'b000) begin
            n_err++; $display("FAIL rmid_async req,busy,wait=%b required=000", {bus.wr_req, busy, bus.ioctl_wait});
        end
        tick();
        reset_n = 1'b1;
        ack_mode = 1;
        for (int i = 0; i < 4; i++) put_byte(27'h90 + 27'(i), 8'($urandom), 0);
        repeat (3) tick();
        n_cmp++;
        if ({bus.wr_req, busy} !== 2'b00) begin
            n_err++; $display("FAIL rmid_ignored req,busy=%b required=00", {bus.wr_req, busy});
        end
        dl(0);
        dl(1);
        put_byte(27'hA0, 8'h5C, 0);
        put_byte(27'hA1, 8'hC5, 0);
        exp_add(WB + 25'h50, 16'hC55C, 2'b11);
        dl(0);
        wait_done();
        n_cmp++;
        if (exp_q.size() !== 0 || done !== 1'b1) begin
            n_err++; $display("FAIL rmid_new_load left=%0d done=%b required 0/1", exp_q.size(), done);
        end
    endtask

    task automatic test_random();
        logic [26:0] a;
        logic [7:0]  d;
        int          r;
        ack_mode = 2;
        for (int run = 0; run < 3; run++) begin
            m_clear();
            a = 27'($urandom);
            dl(1);
            for (int i = 0; i < 40; i++) begin
                r = $urandom_range(0, 9);
                if (r < 6)      a = a + 27'd1;
                else if (r > 7) a = a + 27'($urandom_range(2, 20));
                d = 8'($urandom);
                put_byte(a, d, 1);
                m_byte(a, d);
                repeat ($urandom_range(0, 2)) tick();
            end
            dl(0);
            m_flush();
            wait_done();
            n_cmp++;
            if ({done, overflow} !== 2'b10) begin
                n_err++; $display("FAIL random_end run=%0d done,ovf=%b required=10", run, {done, overflow});
            end
            n_cmp++;
            if (exp_q.size() !== 0) begin n_err++; $display("FAIL random_missing run=%0d left=%0d required=0", run, exp_q.size()); end
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        ack_mode = 0;
        m_clear();
        bus.ioctl_download = 1'b0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = '0;
        test_reset();
        test_basic();
        test_partial();
        test_no_merge();
        test_backpressure();
        test_overflow();
        test_drain_restart();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
